trap_hazard_ctrl: RTL

Parametrised successor to the core's hazard/exception unit. Produces the per-cycle `hazard_signal` for the pipeline and carries fetch/decode exceptions down a configurable-depth side pipe so each one retires as a trap in order, alongside memory-stage MMU faults. It adds three things:
- a registered trap-cause/tval output with a one-cycle post-trap holdoff;
- N-way stall-source merging;
- an optional MMU-stall watchdog.

It sits beside the main pipe registers and drives the CSR trap logic.

---
 rtl/trap_hazard_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/trap_hazard_ctrl.sv
// trap_hazard_ctrl: pipeline hazard_signal, exception side pipe and registered trap outputs.
// Optional MMU-stall watchdog is compiled in with `define HAZARD_WDOG_EN.
module trap_hazard_ctrl #(
  parameter int XLEN          = 32,
  parameter int NUM_STAGES    = 3,
  parameter int NUM_STALL_SRC = 2,
  parameter int WDOG_CYCLES   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [4:0]               IFrs1,
  input  logic [4:0]               IFrs2,
  input  logic [4:0]               IDrd,
  input  logic                     IDmemRead,
  input  logic                     PCSel,
  input  logic                     csr_branch_signal,
  input  logic                     jump_taken,
  input  logic [NUM_STALL_SRC-1:0] stall_src,
  input  logic                     fetch_exc_valid,
  input  logic [4:0]               fetch_exc_cause,
  input  logic [XLEN-1:0]          fetch_exc_tval,
  input  logic                     invalid_inst,
  input  logic [31:0]              faulting_inst_i,
  input  logic                     dmem_load_fault,
  input  logic                     dmem_store_fault,
  input  logic [XLEN-1:0]          dmem_fault_va,
  output logic [3:0]               hazard_signal,
  output logic                     trap_valid,
  output logic [4:0]               trap_cause,
  output logic [XLEN-1:0]          trap_tval,
  output logic                     stall_timeout
);

  localparam logic [3:0] HS_DN       = 4'd0;
  localparam logic [3:0] STALL_EARLY = 4'd1;
  localparam logic [3:0] STALL_MMU   = 4'd2;
  localparam logic [3:0] FLUSH_EARLY = 4'd3;
  localparam logic [3:0] FLUSH_ALL   = 4'd4;
  localparam int         LAST        = NUM_STAGES - 1;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_LD_PF   = 5'd13;
  localparam logic [4:0] CAUSE_ST_PF   = 5'd15;

  logic            slot_vld   [NUM_STAGES];
  logic [4:0]      slot_cause [NUM_STAGES];
  logic [XLEN-1:0] slot_tval  [NUM_STAGES];
  logic [31:0]     slot_inst  [NUM_STAGES];

  logic            nxt_vld    [NUM_STAGES];
  logic [4:0]      nxt_cause  [NUM_STAGES];
  logic [XLEN-1:0] nxt_tval   [NUM_STAGES];
  logic [31:0]     nxt_inst   [NUM_STAGES];

  logic            ent_vld;
  logic [4:0]      ent_cause;
  logic [XLEN-1:0] ent_tval;
  logic [31:0]     ent_inst;

  logic            trap_req;
  logic [4:0]      req_cause;
  logic [XLEN-1:0] req_tval;
  logic            load_use;

  // Oldest faulting instruction first; the registered pulse masks the drain cycle
  always_comb begin
    trap_req  = 1'b0;
    req_cause = '0;
    req_tval  = '0;
    if (slot_vld[LAST]) begin
      trap_req  = 1'b1;
      req_cause = slot_cause[LAST];
      req_tval  = slot_tval[LAST];
    end else if (dmem_load_fault) begin
      trap_req  = 1'b1;
      req_cause = CAUSE_LD_PF;
      req_tval  = dmem_fault_va;
    end else if (dmem_store_fault) begin
      trap_req  = 1'b1;
      req_cause = CAUSE_ST_PF;
      req_tval  = dmem_fault_va;
    end
    if (trap_valid) trap_req = 1'b0;
  end

  assign load_use = IDmemRead && (IDrd != 5'd0) && ((IDrd == IFrs1) || (IDrd == IFrs2));

  always_comb begin
    if (PCSel || csr_branch_signal || trap_req) hazard_signal = FLUSH_ALL;
    else if (jump_taken)                        hazard_signal = FLUSH_EARLY;
    else if (|stall_src)                        hazard_signal = STALL_MMU;
    else if (load_use)                          hazard_signal = STALL_EARLY;
    else                                        hazard_signal = HS_DN;
  end

  // An older fetch fault in slot 0 outranks the decoder's illegal-instruction flag
  assign ent_vld   = slot_vld[0] | invalid_inst;
  assign ent_cause = slot_vld[0] ? slot_cause[0] : CAUSE_ILLEGAL;
  assign ent_tval  = slot_vld[0] ? slot_tval[0]  : XLEN'(faulting_inst_i);
  assign ent_inst  = slot_vld[0] ? slot_inst[0]  : faulting_inst_i;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt_vld[k]   = slot_vld[k];
      nxt_cause[k] = slot_cause[k];
      nxt_tval[k]  = slot_tval[k];
      nxt_inst[k]  = slot_inst[k];
    end
    case (hazard_signal)
      HS_DN, FLUSH_EARLY: begin
        nxt_vld[0]   = (hazard_signal == HS_DN) && fetch_exc_valid;
        nxt_cause[0] = fetch_exc_cause;
        nxt_tval[0]  = fetch_exc_tval;
        nxt_inst[0]  = '0;
        nxt_vld[1]   = ent_vld;
        nxt_cause[1] = ent_cause;
        nxt_tval[1]  = ent_tval;
        nxt_inst[1]  = ent_inst;
        for (int k = 2; k < NUM_STAGES; k++) begin
          nxt_vld[k]   = slot_vld[k-1];
          nxt_cause[k] = slot_cause[k-1];
          nxt_tval[k]  = slot_tval[k-1];
          nxt_inst[k]  = slot_inst[k-1];
        end
      end
      STALL_EARLY: begin
        nxt_vld[1] = 1'b0;
        for (int k = 2; k < NUM_STAGES; k++) begin
          nxt_vld[k]   = slot_vld[k-1];
          nxt_cause[k] = slot_cause[k-1];
          nxt_tval[k]  = slot_tval[k-1];
          nxt_inst[k]  = slot_inst[k-1];
        end
      end
      FLUSH_ALL: begin
        for (int k = 0; k < NUM_STAGES; k++) nxt_vld[k] = 1'b0;
      end
      default: ;
    endcase
  end

  // Slot state boundary: valids are reset, payload follows its valid
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (rst) slot_vld[k] <= 1'b0;
      else     slot_vld[k] <= nxt_vld[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      slot_cause[k] <= nxt_cause[k];
      slot_tval[k]  <= nxt_tval[k];
      slot_inst[k]  <= nxt_inst[k];
    end
  end

  // Trap output boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_valid <= 1'b0;
      trap_cause <= '0;
      trap_tval  <= '0;
    end else begin
      trap_valid <= trap_req;
      trap_cause <= trap_req ? req_cause : 5'd0;
      trap_tval  <= trap_req ? req_tval  : '0;
    end
  end

  logic unused_inst;
  assign unused_inst = ^slot_inst[LAST];

`ifdef HAZARD_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);
  logic [CNT_W-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt      <= '0;
      stall_timeout <= 1'b0;
    end else if (hazard_signal == STALL_MMU) begin
      if (wdog_cnt != CNT_W'(WDOG_CYCLES)) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt >= CNT_W'(WDOG_CYCLES - 1)) stall_timeout <= 1'b1;
    end else begin
      wdog_cnt <= '0;
    end
  end
`else
  assign stall_timeout = 1'b0;
`endif

endmodule
